// File: rtl/request_issuer.sv
// request_issuer: buffers trace entries and issues them to the request queue.
// Optional stall/retry statistics are built when ISSUER_STATS_EN is defined.
module request_issuer #(
    parameter int DEPTH  = 8,
    parameter int TIME_W = 64,
    parameter int ADDR_W = 33,
    parameter int OP_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [TIME_W-1:0] ld_time,
    input  logic [OP_W-1:0]   ld_opcode,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_err,
    output logic              op_ready_s,
    output logic [TIME_W-1:0] out_time_cpu,
    output logic [OP_W-1:0]   out_opcode,
    output logic [ADDR_W-1:0] out_address,
    input  logic              pending_request,
    input  logic              queue_full,
    input  logic [TIME_W-1:0] queue_time,
    output logic [31:0]       issued_count,
    output logic              busy,
    output logic [31:0]       stall_cycles,
    output logic [15:0]       retry_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE_C   = (PW+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CHECK,
        BACKOFF
    } state_t;

    state_t state;

    logic [TIME_W-1:0] mem_time [DEPTH];
    logic [OP_W-1:0]   mem_op   [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic [PW:0]       count_next;
    logic [TIME_W-1:0] last_time;

    logic empty;
    logic ld_fire;
    logic push;
    logic pop;
    logic more_next;

    assign empty    = (count == '0);
    assign ld_ready = (count < DEPTH_C);
    assign ld_fire  = ld_valid && ld_ready;
    assign push     = ld_fire && (ld_time >= last_time);
    assign pop      = (state == CHECK) && !pending_request;
    assign busy     = !empty || (state != IDLE);

    assign out_time_cpu = empty ? '0 : mem_time[rd_ptr];
    assign out_opcode   = empty ? '0 : mem_op[rd_ptr];
    assign out_address  = empty ? '0 : mem_addr[rd_ptr];

    // Occupancy after this cycle's push/pop, used for back-to-back issue.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + ONE_C;
        end else if (pop && !push) begin
            count_next = count - ONE_C;
        end
    end

    assign more_next = (count_next != '0);

    // FIFO pointers, occupancy, ordering check and reject pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_time <= '0;
            ld_err    <= 1'b0;
        end else begin
            ld_err <= ld_fire && !push;
            count  <= count_next;
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                last_time <= ld_time;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Entry storage; contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_time[wr_ptr] <= ld_time;
            mem_op[wr_ptr]   <= ld_opcode;
            mem_addr[wr_ptr] <= ld_addr;
        end
    end

    // Issue handshake: strobe, check refusal, back off until the queue catches up.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            op_ready_s   <= 1'b0;
            issued_count <= '0;
        end else begin
            op_ready_s <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!empty && !queue_full) begin
                        state      <= ISSUE;
                        op_ready_s <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (pending_request) begin
                        state <= BACKOFF;
                    end else begin
                        issued_count <= issued_count + 32'd1;
                        if (more_next && !queue_full) begin
                            state      <= ISSUE;
                            op_ready_s <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                BACKOFF: begin
                    if (!queue_full && queue_time >= out_time_cpu) begin
                        state      <= ISSUE;
                        op_ready_s <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ISSUER_STATS_EN
    logic stall_now;
    logic refuse_now;

    assign stall_now  = (state == BACKOFF) ||
                        ((state == IDLE) && !empty && queue_full);
    assign refuse_now = (state == CHECK) && pending_request;

    // Saturating stall and refusal counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            retry_count  <= '0;
        end else begin
            if (stall_now && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (refuse_now && (retry_count != '1)) begin
                retry_count <= retry_count + 16'd1;
            end
        end
    end
`else
    assign stall_cycles = '0;
    assign retry_count  = '0;
`endif

endmodule
